instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 96 +++++++++
 tb/tb_instruction_fetch.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: pulls 1-3 byte instructions from a byte-wide memory,
// one byte per handshake, and holds the assembled instruction for the decoder.
module instruction_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  output logic        pcEnable,
  output logic [15:0] memAddr,
  output logic        memRead,
  input  logic        memReady,
  input  logic [7:0]  memData,
  input  logic        flush,
  output logic [23:0] instr,
  output logic [1:0]  instrLen,
  output logic        instrValid,
  input  logic        instrReady
);

  typedef enum logic [1:0] {
    StFetchOp = 2'd0,
    StFetchB1 = 2'd1,
    StFetchB2 = 2'd2,
    StHold    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] instr_q, instr_d;
  logic [1:0]  len_q, len_d;
  logic [1:0]  op_len;
  logic        xfer;

  always_comb begin
    unique case (memData[7:6])
      2'b00:   op_len = 2'd1;
      2'b01:   op_len = 2'd2;
      default: op_len = 2'd3;
    endcase
  end

  // Reset and flush gate the request so a concurrent PC load is never disturbed.
  assign memAddr    = pc;
  assign memRead    = reset && !flush && (state_q != StHold);
  assign xfer       = memRead && memReady;
  assign pcEnable   = xfer;
  assign instrValid = (state_q == StHold);
  assign instr      = instr_q;
  assign instrLen   = len_q;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    len_d   = len_q;
    if (flush) begin
      state_d = StFetchOp;
    end else begin
      unique case (state_q)
        StFetchOp: begin
          if (xfer) begin
            instr_d = {memData, 16'h0000};
            len_d   = op_len;
            state_d = (op_len == 2'd1) ? StHold : StFetchB1;
          end
        end
        StFetchB1: begin
          if (xfer) begin
            instr_d[15:8] = memData;
            state_d       = (len_q == 2'd2) ? StHold : StFetchB2;
          end
        end
        StFetchB2: begin
          if (xfer) begin
            instr_d[7:0] = memData;
            state_d      = StHold;
          end
        end
        StHold: begin
          if (instrReady) state_d = StFetchOp;
        end
        default: state_d = StFetchOp;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetchOp;
      instr_q <= 24'h000000;
      len_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed vectors push expected
// instructions; a monitor pops and compares on each decoder handshake.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic [15:0] pc;
  logic        pcEnable;
  logic [15:0] memAddr;
  logic        memRead;
  logic        memReady;
  logic [7:0]  memData;
  logic        flush;
  logic [23:0] instr;
  logic [1:0]  instrLen;
  logic        instrValid;
  logic        instrReady;

  logic [7:0]  mem [0:255];
  logic        pc_load;
  logic [15:0] pc_load_val;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [23:0] ins;
    logic [1:0]  len;
  } exp_t;
  exp_t exp_q [$];

  instruction_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .pcEnable   (pcEnable),
    .memAddr    (memAddr),
    .memRead    (memRead),
    .memReady   (memReady),
    .memData    (memData),
    .flush      (flush),
    .instr      (instr),
    .instrLen   (instrLen),
    .instrValid (instrValid),
    .instrReady (instrReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program counter model: external load wins, otherwise advance on pcEnable.
  always @(posedge clk) begin
    if (pc_load) pc <= pc_load_val;
    else if (pcEnable) pc <= pc + 16'd1;
  end

  assign memData = mem[memAddr[7:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load_pc(input logic [15:0] v);
    step();
    memReady    = 1'b0;
    pc_load     = 1'b1;
    pc_load_val = v;
    step();
    pc_load     = 1'b0;
  endtask

  // Monitor: samples after stimulus has settled for the coming edge.
  always @(negedge clk) begin
    #2;
    if (reset && instrValid && instrReady && !flush) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {31'd0, instrValid}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("instr", {8'd0, instr}, {8'd0, e.ins});
        check("instrLen", {30'd0, instrLen}, {30'd0, e.len});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h05;
    mem[8'hF0] = 8'h80; mem[8'hF1] = 8'h34; mem[8'hF2] = 8'h12;
    mem[8'h10] = 8'h41; mem[8'h11] = 8'hAB;
    mem[8'h20] = 8'h3F;
    mem[8'h30] = 8'h80; mem[8'h31] = 8'h11;
    mem[8'h40] = 8'hC0; mem[8'h41] = 8'h77;

    reset       = 1'b0;
    memReady    = 1'b0;
    flush       = 1'b0;
    instrReady  = 1'b1;
    pc_load     = 1'b1;
    pc_load_val = 16'h0000;
    step();
    step();
    pc_load = 1'b0;
    #1;
    check("rst_instrValid", {31'd0, instrValid}, 32'd0);
    check("rst_memRead", {31'd0, memRead}, 32'd0);
    check("rst_pcEnable", {31'd0, pcEnable}, 32'd0);
    check("rst_instr", {8'd0, instr}, 32'd0);
    check("rst_instrLen", {30'd0, instrLen}, 32'd0);

    // Single-byte opcode at 0x0000, first memRead right after reset release.
    step();
    reset    = 1'b1;
    memReady = 1'b1;
    exp_q.push_back('{ins: 24'h050000, len: 2'd1});
    #1;
    check("t1_memRead", {31'd0, memRead}, 32'd1);
    check("t1_memAddr", {16'd0, memAddr}, 32'h0000);
    check("t1_pcEnable", {31'd0, pcEnable}, 32'd1);
    step();
    memReady = 1'b0;
    #1;
    check("t1_valid", {31'd0, instrValid}, 32'd1);
    check("t1_hold_pcEnable", {31'd0, pcEnable}, 32'd0);

    // Three-byte instruction at 0x00F0.
    load_pc(16'h00F0);
    memReady = 1'b1;
    exp_q.push_back('{ins: 24'h803412, len: 2'd3});
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2_memAddr", {16'd0, memAddr}, 32'h00F0 + i);
      check("t2_pcEnable", {31'd0, pcEnable}, 32'd1);
      step();
    end
    memReady = 1'b0;
    #1;
    check("t2_valid", {31'd0, instrValid}, 32'd1);

    // Two-byte instruction with memory stalled in FETCH_B1.
    load_pc(16'h0010);
    memReady = 1'b1;
    exp_q.push_back('{ins: 24'h41AB00, len: 2'd2});
    step();
    memReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("t3_stall_memRead", {31'd0, memRead}, 32'd1);
      check("t3_stall_pcEnable", {31'd0, pcEnable}, 32'd0);
      check("t3_stall_memAddr", {16'd0, memAddr}, 32'h0011);
      step();
    end
    memReady = 1'b1;
    #1;
    check("t3_pcEnable", {31'd0, pcEnable}, 32'd1);
    step();
    memReady = 1'b0;
    #1;
    check("t3_valid", {31'd0, instrValid}, 32'd1);

    // Decoder back-pressure in HOLD; memory stays ready to catch any prefetch.
    load_pc(16'h0020);
    instrReady = 1'b0;
    memReady   = 1'b1;
    exp_q.push_back('{ins: 24'h3F0000, len: 2'd1});
    step();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_valid", {31'd0, instrValid}, 32'd1);
      check("t4_instr", {8'd0, instr}, 32'h3F0000);
      check("t4_memRead", {31'd0, memRead}, 32'd0);
      check("t4_pcEnable", {31'd0, pcEnable}, 32'd0);
      step();
    end
    instrReady = 1'b1;
    memReady   = 1'b0;
    step();
    #1;
    check("t4_resume_valid", {31'd0, instrValid}, 32'd0);
    check("t4_resume_memRead", {31'd0, memRead}, 32'd1);
    check("t4_resume_memAddr", {16'd0, memAddr}, 32'h0021);

    // Flush in FETCH_B1 discards the 3-byte opcode; fetch restarts at 0x0031.
    load_pc(16'h0030);
    memReady = 1'b1;
    step();
    flush = 1'b1;
    #1;
    check("t5_flush_pcEnable", {31'd0, pcEnable}, 32'd0);
    check("t5_flush_memRead", {31'd0, memRead}, 32'd0);
    step();
    flush    = 1'b0;
    memReady = 1'b0;
    #1;
    check("t5_after_memRead", {31'd0, memRead}, 32'd1);
    check("t5_after_valid", {31'd0, instrValid}, 32'd0);
    check("t5_after_memAddr", {16'd0, memAddr}, 32'h0031);
    step();
    memReady = 1'b1;
    exp_q.push_back('{ins: 24'h110000, len: 2'd1});
    step();
    memReady = 1'b0;
    #1;
    check("t5_valid", {31'd0, instrValid}, 32'd1);

    // Reset asserted mid-FETCH_B1.
    load_pc(16'h0040);
    memReady = 1'b1;
    step();
    memReady = 1'b0;
    #1;
    check("t6_partial_instr", {8'd0, instr}, 32'hC00000);
    reset = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, instrValid}, 32'd0);
    check("t6_rst_memRead", {31'd0, memRead}, 32'd0);
    check("t6_rst_pcEnable", {31'd0, pcEnable}, 32'd0);
    check("t6_rst_instr", {8'd0, instr}, 32'd0);
    step();
    reset = 1'b1;
    #1;
    check("t6_rel_memRead", {31'd0, memRead}, 32'd1);
    check("t6_rel_memAddr", {16'd0, memAddr}, {16'd0, pc});
    check("t6_rel_pc", {16'd0, pc}, 32'h0041);
    step();
    step();

    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
